// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and store-side helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEF = 255;

    // Unknown funct3 codes fall through to a word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3_size(f3))
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_ld_align.sv
// Load data extraction: selects the addressed lane and sign/zero extends it.
module ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata >> {offset, 3'b000};

    // Lane select and extension; word accesses are aligned so use rdata as-is.
    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   data = {24'h00_0000, shifted_s[7:0]};
            F3_H:    data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   data = {16'h0000, shifted_s[15:0]};
            F3_W:    data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: aligns accesses, drives a req/gnt/rvalid
// data-memory port, stalls the pipeline and flags misalignment or timeout.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        misalign,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    lsu_state_e  state_r, state_s;
    logic [31:0] addr_r;
    logic [2:0]  f3_r;
    logic        wr_r;
    logic [31:0] st_data_r;
    logic [CW-1:0] cnt_r;
    logic [31:0] ld_data_r;
    logic        err_r;

    logic        mis_s;
    logic        capture_s;
    logic        to_fire_s;
    logic        in_req_s;
    logic [31:0] ld_aligned_s;

    assign mis_s    = is_misaligned(funct3, addr[1:0]);
    assign in_req_s = (state_r == REQ);

    ld_align u_ld_align (
        .rdata  (dmem_rdata),
        .offset (addr_r[1:0]),
        .funct3 (f3_r),
        .data   (ld_aligned_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a grant or data beat wins over a coincident timeout.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        to_fire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_en && !mis_s) state_s = REQ;
                else                  state_s = IDLE;
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (wr_r) begin
                        state_s = DONE;
                    end else if (dmem_rvalid) begin
                        state_s   = DONE;
                        capture_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                    end
                end else if (cnt_r >= TO_LAST) begin
                    state_s   = DONE;
                    to_fire_s = 1'b1;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_s   = DONE;
                    capture_s = 1'b1;
                end else if (cnt_r >= TO_LAST) begin
                    state_s   = DONE;
                    to_fire_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Access latch, timeout counter, load result and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r    <= 32'h0000_0000;
            f3_r      <= 3'b000;
            wr_r      <= 1'b0;
            st_data_r <= 32'h0000_0000;
            cnt_r     <= '0;
            ld_data_r <= 32'h0000_0000;
            err_r     <= 1'b0;
        end else begin
            if (state_r == IDLE && state_s == REQ) begin
                addr_r    <= addr;
                f3_r      <= funct3;
                wr_r      <= mem_wr;
                st_data_r <= st_data;
                cnt_r     <= '0;
            end else if (state_r == REQ || state_r == WAIT) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (capture_s) begin
                ld_data_r <= ld_aligned_s;
            end else if (to_fire_s) begin
                ld_data_r <= 32'h0000_0000;
            end else begin
                ld_data_r <= ld_data_r;
            end
            err_r <= to_fire_s;
        end
    end

    // Pipeline stall: in IDLE only a legal new access stalls.
    always_comb begin
        lsu_stall = 1'b0;
        case (state_r)
            IDLE:    lsu_stall = mem_en & ~mis_s;
            REQ:     lsu_stall = 1'b1;
            WAIT:    lsu_stall = 1'b1;
            DONE:    lsu_stall = 1'b0;
            default: lsu_stall = 1'b0;
        endcase
    end

    assign ld_data    = ld_data_r;
    assign lsu_done   = (state_r == DONE);
    assign bus_err    = err_r;
    assign misalign   = (state_r == IDLE) & mem_en & mis_s;
    assign dmem_req   = in_req_s;
    assign dmem_we    = in_req_s & wr_r;
    assign dmem_addr  = in_req_s ? {addr_r[31:2], 2'b00} : 32'h0000_0000;
    assign dmem_be    = in_req_s ? store_be(f3_r, addr_r[1:0]) : 4'b0000;
    assign dmem_wdata = in_req_s ? store_wdata(f3_r, st_data_r) : 32'h0000_0000;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short timeout so the bus-error path is reachable.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_en;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        lsu_stall;
    logic        lsu_done;
    logic        misalign;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_pass  = 0;
    int n_total = 0;
    int stalls  = 0;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .funct3      (funct3),
        .addr        (addr),
        .st_data     (st_data),
        .ld_data     (ld_data),
        .lsu_stall   (lsu_stall),
        .lsu_done    (lsu_done),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        addr = 32'h0; st_data = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        tick(); tick();
        rst_n = 1'b1;
        smp();
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_stall", {31'h0, lsu_stall}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_done", {31'h0, lsu_done}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);

        // LB at 0x1003: gnt in REQ, rvalid in WAIT
        tick();
        mem_en = 1'b1; mem_wr = 1'b0; funct3 = 3'b000; addr = 32'h0000_1003;
        smp();
        chk("lb_idle_stall", {31'h0, lsu_stall}, 32'h1);
        chk("lb_idle_req", {31'h0, dmem_req}, 32'h0);
        stalls = stalls + int'(lsu_stall);
        tick();
        dmem_gnt = 1'b1; mem_en = 1'b0;
        smp();
        chk("lb_req", {31'h0, dmem_req}, 32'h1);
        chk("lb_addr", dmem_addr, 32'h0000_1000);
        stalls = stalls + int'(lsu_stall);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
        smp();
        chk("lb_wait_req", {31'h0, dmem_req}, 32'h0);
        stalls = stalls + int'(lsu_stall);
        tick();
        dmem_rvalid = 1'b0;
        smp();
        chk("lb_done", {31'h0, lsu_done}, 32'h1);
        chk("lb_done_stall", {31'h0, lsu_stall}, 32'h0);
        chk("lb_stall_cycles", stalls, 32'd3);
        chk("lb_ld_data", ld_data, 32'hFFFF_FF80);
        tick();
        smp();
        chk("lb_done_pulse", {31'h0, lsu_done}, 32'h0);
        chk("lb_ld_hold", ld_data, 32'hFFFF_FF80);

        // SH at 0x2002, completes on gnt
        mem_en = 1'b1; mem_wr = 1'b1; funct3 = 3'b001; addr = 32'h0000_2002; st_data = 32'h0000_ABCD;
        tick();
        mem_en = 1'b0; addr = 32'h0000_0000; st_data = 32'h0; dmem_gnt = 1'b1;
        smp();
        chk("sh_req", {31'h0, dmem_req}, 32'h1);
        chk("sh_we", {31'h0, dmem_we}, 32'h1);
        chk("sh_be", {28'h0, dmem_be}, 32'h0000_000C);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", dmem_addr, 32'h0000_2000);
        tick();
        dmem_gnt = 1'b0;
        smp();
        chk("sh_done", {31'h0, lsu_done}, 32'h1);
        chk("sh_ld_hold", ld_data, 32'hFFFF_FF80);
        tick();

        // SB at 0x7001
        mem_en = 1'b1; mem_wr = 1'b1; funct3 = 3'b000; addr = 32'h0000_7001; st_data = 32'h1234_565A;
        tick();
        mem_en = 1'b0; dmem_gnt = 1'b1;
        smp();
        chk("sb_be", {28'h0, dmem_be}, 32'h0000_0002);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        tick();
        dmem_gnt = 1'b0;
        smp();
        chk("sb_done", {31'h0, lsu_done}, 32'h1);
        tick();

        // LW at 0x3001 is misaligned: no request, no stall
        mem_en = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h0000_3001;
        smp();
        chk("lw_mis", {31'h0, misalign}, 32'h1);
        chk("lw_mis_stall", {31'h0, lsu_stall}, 32'h0);
        chk("lw_mis_req", {31'h0, dmem_req}, 32'h0);
        tick();
        smp();
        chk("lw_mis_req2", {31'h0, dmem_req}, 32'h0);
        chk("lw_mis_done", {31'h0, lsu_done}, 32'h0);
        mem_en = 1'b0;

        // Grant withheld: bus error after 4 REQ cycles
        tick();
        mem_en = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000;
        tick();
        mem_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("to_req_held", {31'h0, dmem_req}, 32'h1);
            chk("to_no_err", {31'h0, bus_err}, 32'h0);
            tick();
        end
        smp();
        chk("to_bus_err", {31'h0, bus_err}, 32'h1);
        chk("to_ld_zero", ld_data, 32'h0);
        chk("to_req_drop", {31'h0, dmem_req}, 32'h0);
        chk("to_done", {31'h0, lsu_done}, 32'h1);
        tick();
        smp();
        chk("to_err_pulse", {31'h0, bus_err}, 32'h0);
        chk("to_idle_done", {31'h0, lsu_done}, 32'h0);
        chk("to_idle_req", {31'h0, dmem_req}, 32'h0);

        // LHU at 0x5002 with gnt and rvalid together
        tick();
        mem_en = 1'b1; mem_wr = 1'b0; funct3 = 3'b101; addr = 32'h0000_5002;
        tick();
        mem_en = 1'b0; dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFEDC_0000;
        smp();
        chk("lhu_req", {31'h0, dmem_req}, 32'h1);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        smp();
        chk("lhu_done", {31'h0, lsu_done}, 32'h1);
        chk("lhu_ld_data", ld_data, 32'h0000_FEDC);
        tick();

        // Reset during WAIT, then a late rvalid
        mem_en = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h0000_6000;
        tick();
        mem_en = 1'b0; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        smp();
        chk("rw_wait_stall", {31'h0, lsu_stall}, 32'h1);
        chk("rw_wait_req", {31'h0, dmem_req}, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        smp();
        chk("rw_ld_zero", ld_data, 32'h0);
        chk("rw_no_done", {31'h0, lsu_done}, 32'h0);
        chk("rw_no_req", {31'h0, dmem_req}, 32'h0);
        chk("rw_no_stall", {31'h0, lsu_stall}, 32'h0);
        tick();
        dmem_rvalid = 1'b0;
        smp();
        chk("rw_ld_zero2", ld_data, 32'h0);
        chk("rw_no_done2", {31'h0, lsu_done}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
